// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit: main decoder, ALU decoder and ALU for the ID/EX boundary.
// Decodes the opcode into the 8-bit control bundle
// {ALUSrc, MemtoReg, MemRead, MemWrite, Branch, RegWrite, ALUOp[1:0]}.
// It derives the 4-bit ALU operation, selects operand B and computes the
// result. All outputs are registered, giving one cycle of latency.
// Optional feature macro: ALU_EXT_OPS_EN enables XOR/shift/compare operations.
// When the macro is absent, only AND/OR/ADD/SUB are decoded and implemented.
module exec_ctrl_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        bubble,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        instr30,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] imm,
  output logic        out_valid,
  output logic [7:0]  ctrl,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] store_data
);

  // Opcodes recognised by the main decoder
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;

  // Control bundles, MSB first: ALUSrc MemtoReg MemRead MemWrite Branch RegWrite ALUOp[1:0]
  localparam logic [7:0] CTRL_RTYPE  = 8'h06;
  localparam logic [7:0] CTRL_LOAD   = 8'hE4;
  localparam logic [7:0] CTRL_STORE  = 8'h90;
  localparam logic [7:0] CTRL_BRANCH = 8'h09;
  localparam logic [7:0] CTRL_IALU   = 8'h87;
  localparam logic [7:0] CTRL_NONE   = 8'h00;

  // ALU operation encodings
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
`ifdef ALU_EXT_OPS_EN
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
`endif

  // Opcode to control bundle; unknown opcodes produce an all-zero bundle
  function automatic logic [7:0] main_decode(input logic [6:0] opc);
    logic [7:0] bundle;
    case (opc)
      OPC_RTYPE:  bundle = CTRL_RTYPE;
      OPC_LOAD:   bundle = CTRL_LOAD;
      OPC_STORE:  bundle = CTRL_STORE;
      OPC_BRANCH: bundle = CTRL_BRANCH;
      OPC_IALU:   bundle = CTRL_IALU;
      default:    bundle = CTRL_NONE;
    endcase
    return bundle;
  endfunction

  // ALUOp/funct3/instr30 to ALU operation. For immediates (ALUOp 11)
  // instr30 only matters for the right-shift pair, so ADDI never becomes SUB.
  function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [2:0] f3,
                                            input logic       i30);
    logic [3:0] code;
    code = ALU_ADD;
    case (alu_op)
      2'b00: code = ALU_ADD;
      2'b01: code = ALU_SUB;
      2'b10, 2'b11: begin
        case (f3)
          3'b000: begin
            if ((alu_op == 2'b10) && i30) begin
              code = ALU_SUB;
            end else begin
              code = ALU_ADD;
            end
          end
          3'b111: code = ALU_AND;
          3'b110: code = ALU_OR;
`ifdef ALU_EXT_OPS_EN
          3'b100: code = ALU_XOR;
          3'b001: code = ALU_SLL;
          3'b101: begin
            if (i30) begin
              code = ALU_SRA;
            end else begin
              code = ALU_SRL;
            end
          end
          3'b010: code = ALU_SLT;
          3'b011: code = ALU_SLTU;
`endif
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // ALU datapath; shifts use only the low five bits of B, unused codes give 0
  function automatic logic [31:0] alu_compute(input logic [3:0]  code,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] res;
    case (code)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
`ifdef ALU_EXT_OPS_EN
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << b[4:0];
      ALU_SRL:  res = a >> b[4:0];
      ALU_SRA:  res = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  res = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {31'd0, (a < b)};
`endif
      default:  res = 32'd0;
    endcase
    return res;
  endfunction

  logic [7:0]  ctrl_dec_s;
  logic [7:0]  ctrl_next_s;
  logic [31:0] operand_b_s;
  logic [3:0]  alu_ctrl_s;
  logic [31:0] alu_res_s;

  logic        out_valid_r;
  logic [7:0]  ctrl_r;
  logic [3:0]  alu_ctrl_r;
  logic [31:0] result_r;
  logic        zero_r;
  logic [31:0] store_data_r;

  // Decode and execute; ALUSrc and ALUOp come from the unmasked bundle so a
  // bubble only suppresses the control side effects, not the computation
  always_comb begin
    ctrl_dec_s  = main_decode(opcode);
    operand_b_s = op_b;
    if (ctrl_dec_s[7]) begin
      operand_b_s = imm;
    end else begin
      operand_b_s = op_b;
    end
    alu_ctrl_s = alu_decode(ctrl_dec_s[1:0], funct3, instr30);
    alu_res_s  = alu_compute(alu_ctrl_s, op_a, operand_b_s);
    if (bubble) begin
      ctrl_next_s = CTRL_NONE;
    end else begin
      ctrl_next_s = ctrl_dec_s;
    end
  end

  // Output register; reset discards any in-flight operation and reports zero=1
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      ctrl_r       <= 8'h00;
      alu_ctrl_r   <= 4'h0;
      result_r     <= 32'd0;
      zero_r       <= 1'b1;
      store_data_r <= 32'd0;
    end else begin
      out_valid_r  <= in_valid;
      ctrl_r       <= ctrl_next_s;
      alu_ctrl_r   <= alu_ctrl_s;
      result_r     <= alu_res_s;
      zero_r       <= (alu_res_s == 32'd0);
      store_data_r <= op_b;
    end
  end

  assign out_valid  = out_valid_r;
  assign ctrl       = ctrl_r;
  assign alu_ctrl   = alu_ctrl_r;
  assign result     = result_r;
  assign zero       = zero_r;
  assign store_data = store_data_r;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Scoreboard testbench for exec_ctrl_unit: the driver pushes expected
// responses, and a separate monitor pops and compares one per clock.
module tb_exec_ctrl_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        bubble;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        instr30;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] imm;
  logic        out_valid;
  logic [7:0]  ctrl;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic [31:0] store_data;

  exec_ctrl_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bubble(bubble),
    .opcode(opcode), .funct3(funct3), .instr30(instr30),
    .op_a(op_a), .op_b(op_b), .imm(imm),
    .out_valid(out_valid), .ctrl(ctrl), .alu_ctrl(alu_ctrl),
    .result(result), .zero(zero), .store_data(store_data)
  );

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [3:0]  alu;
    logic [31:0] res;
    logic        zero;
    logic [31:0] sd;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   ext_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the instruction-level rules
  function automatic exp_t model(input logic v, input logic bub, input logic [6:0] opc,
                                 input logic [2:0] f3, input logic i30,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im);
    exp_t e;
    logic [7:0] c;
    logic [31:0] bb;
    string op;
    int sh;
    case (opc)
      7'b0110011: c = 8'h06;
      7'b0000011: c = 8'hE4;
      7'b0100011: c = 8'h90;
      7'b1100011: c = 8'h09;
      7'b0010011: c = 8'h87;
      default:    c = 8'h00;
    endcase
    bb = c[7] ? im : b;
    if (c[1:0] == 2'b00) op = "add";
    else if (c[1:0] == 2'b01) op = "sub";
    else begin
      case (f3)
        3'b000: op = (c[1:0] == 2'b10 && i30) ? "sub" : "add";
        3'b111: op = "and";
        3'b110: op = "or";
        3'b100: op = ext_en ? "xor" : "add";
        3'b001: op = ext_en ? "sll" : "add";
        3'b101: op = ext_en ? (i30 ? "sra" : "srl") : "add";
        3'b010: op = ext_en ? "slt" : "add";
        default: op = ext_en ? "sltu" : "add";
      endcase
    end
    sh = int'(bb % 32);
    case (op)
      "add":  begin e.alu = 4'd2; e.res = a + bb; end
      "sub":  begin e.alu = 4'd6; e.res = a - bb; end
      "and":  begin e.alu = 4'd0; e.res = a & bb; end
      "or":   begin e.alu = 4'd1; e.res = a | bb; end
      "xor":  begin e.alu = 4'd3; e.res = a ^ bb; end
      "sll":  begin e.alu = 4'd4; e.res = a * (32'd1 << sh); end
      "srl":  begin e.alu = 4'd5; e.res = a / (32'd1 << sh); end
      "sra":  begin
        e.alu = 4'd8;
        e.res = a;
        for (int k = 0; k < sh; k++) e.res = {e.res[31], e.res[31:1]};
      end
      "slt":  begin
        e.alu = 4'd7;
        e.res = ((a[31] && !bb[31]) || (a[31] == bb[31] && a < bb)) ? 32'd1 : 32'd0;
      end
      default: begin e.alu = 4'd9; e.res = (a < bb) ? 32'd1 : 32'd0; end
    endcase
    e.valid = v;
    e.ctrl  = bub ? 8'h00 : c;
    e.zero  = (e.res == 32'd0);
    e.sd    = b;
    return e;
  endfunction

  // Apply inputs on the falling edge so the rising edge samples them cleanly
  task automatic apply(input logic r, input logic v, input logic bub, input logic [6:0] opc,
                       input logic [2:0] f3, input logic i30,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    @(negedge clk);
    rst = r; in_valid = v; bubble = bub; opcode = opc; funct3 = f3;
    instr30 = i30; op_a = a; op_b = b; imm = im;
  endtask

  task automatic issue(input logic r, input logic v, input logic bub, input logic [6:0] opc,
                       input logic [2:0] f3, input logic i30,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    exp_t e;
    apply(r, v, bub, opc, f3, i30, a, b, im);
    if (r) begin
      e.valid = 1'b0; e.ctrl = 8'h00; e.alu = 4'h0; e.res = 32'd0; e.zero = 1'b1; e.sd = 32'd0;
    end else begin
      e = model(v, bub, opc, f3, i30, a, b, im);
    end
    exp_q.push_back(e);
  endtask

  // Issue with hand-computed expectations
  task automatic issue_k(input logic bub, input logic [6:0] opc, input logic [2:0] f3,
                         input logic i30, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [7:0] ec, input logic [3:0] ea,
                         input logic [31:0] er, input logic ez, input logic [31:0] esd);
    exp_t e;
    apply(1'b0, 1'b1, bub, opc, f3, i30, a, b, im);
    e.valid = 1'b1; e.ctrl = ec; e.alu = ea; e.res = er; e.zero = ez; e.sd = esd;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: one registered response per rising edge, sampled 1 time unit later
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_valid",  32'(out_valid),  32'(e.valid));
        check("ctrl",       32'(ctrl),       32'(e.ctrl));
        check("alu_ctrl",   32'(alu_ctrl),   32'(e.alu));
        check("result",     result,          e.res);
        check("zero",       32'(zero),       32'(e.zero));
        check("store_data", store_data,      e.sd);
      end
    end
  end

  logic [6:0] opc_tbl [0:5];

  initial begin
`ifdef ALU_EXT_OPS_EN
    ext_en = 1'b1;
`else
    ext_en = 1'b0;
`endif
    opc_tbl[0] = 7'b0110011; opc_tbl[1] = 7'b0000011; opc_tbl[2] = 7'b0100011;
    opc_tbl[3] = 7'b1100011; opc_tbl[4] = 7'b0010011; opc_tbl[5] = 7'b1111111;
    rst = 1'b1; in_valid = 1'b0; bubble = 1'b0; opcode = 7'd0; funct3 = 3'd0;
    instr30 = 1'b0; op_a = 32'd0; op_b = 32'd0; imm = 32'd0;

    issue(1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    issue(1'b1, 1'b1, 1'b0, 7'b0110011, 3'd0, 1'b0, 32'd9, 32'd1, 32'd0);

    // Directed cases with hand-computed expectations
    issue_k(1'b0, 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 8'h06, 4'b0010, 32'd12, 1'b0, 32'd7);
    issue_k(1'b0, 7'b0110011, 3'b000, 1'b1, 32'd7, 32'd7, 32'd0, 8'h06, 4'b0110, 32'd0, 1'b1, 32'd7);
    issue_k(1'b0, 7'b0000011, 3'b010, 1'b0, 32'h100, 32'hFFFF, 32'h10, 8'hE4, 4'b0010, 32'h110, 1'b0, 32'hFFFF);
    issue_k(1'b0, 7'b0100011, 3'b010, 1'b0, 32'h100, 32'hFFFF, 32'h10, 8'h90, 4'b0010, 32'h110, 1'b0, 32'hFFFF);
    issue_k(1'b0, 7'b1100011, 3'b000, 1'b0, 32'd3, 32'd3, 32'h55, 8'h09, 4'b0110, 32'd0, 1'b1, 32'd3);
    issue_k(1'b0, 7'b1100011, 3'b000, 1'b0, 32'd3, 32'd4, 32'h55, 8'h09, 4'b0110, 32'hFFFFFFFF, 1'b0, 32'd4);
    issue_k(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 8'h00, 4'b0010, 32'd12, 1'b0, 32'd7);
    issue_k(1'b0, 7'b0010011, 3'b000, 1'b1, 32'd1, 32'd9, 32'h400, 8'h87, 4'b0010, 32'h401, 1'b0, 32'd9);
`ifdef ALU_EXT_OPS_EN
    issue_k(1'b0, 7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'd4, 32'd0, 8'h06, 4'b1000, 32'hF8000000, 1'b0, 32'd4);
`else
    issue_k(1'b0, 7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'd4, 32'd0, 8'h06, 4'b0010, 32'h80000004, 1'b0, 32'd4);
`endif
    issue_k(1'b0, 7'b1111111, 3'b111, 1'b0, 32'hF0, 32'h3C, 32'd0, 8'h00, 4'b0010, 32'h12C, 1'b0, 32'h3C);
    // Reset arriving in the middle of a valid stream
    issue(1'b1, 1'b1, 1'b0, 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0);
    issue(1'b0, 1'b1, 1'b0, 7'b0110011, 3'b110, 1'b0, 32'h0F, 32'hF0, 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b, im;
      logic r, v, bub;
      r   = ($urandom_range(0, 49) == 0);
      v   = $urandom_range(0, 3) != 0;
      bub = ($urandom_range(0, 7) == 0);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im  = ($urandom_range(0, 3) == 0) ? (32'd0 - a) : $urandom;
      issue(r, v, bub, opc_tbl[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), a, b, im);
    end

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exec_ctrl_unit.md
# exec_ctrl_unit

Combined main-decoder / ALU-decoder / ALU for the 32-bit RV32I-style five-stage pipeline. It decodes the instruction opcode into the 8-bit pipeline control bundle, derives the 4-bit ALU operation from ALUOp, funct3 and instr[30], selects operand B, and computes result and zero flag. All outputs are registered, giving one cycle of latency. It sits at the ID/EX boundary, feeding the EX/MEM register and the branch mux.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/instruction valid this cycle
- bubble  in  1  hazard-unit stall; forces control bundle to zero
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- instr30  in  1  instr[30]
- op_a  in  32  rs1 value (already forwarded)
- op_b  in  32  rs2 value (already forwarded)
- imm  in  32  sign-extended immediate
- out_valid  out  1  registered in_valid
- ctrl  out  8  {ALUSrc, MemtoReg, MemRead, MemWrite, Branch, RegWrite, ALUOp[1:0]}, MSB first
- alu_ctrl  out  4  decoded ALU operation
- result  out  32  ALU result
- zero  out  1  result == 0
- store_data  out  32  registered op_b, for stores

## Operation
- Main decode (ctrl value):
  - 0110011 R-type → 0x06
  - 0000011 load → 0xE4
  - 0100011 store → 0x90
  - 1100011 branch → 0x09
  - 0010011 I-ALU → 0x87
  - any other opcode → 0x00
- bubble=1 → ctrl=0x00 regardless of opcode; ALU still computes from the undecoded operands.
- Operand B = ALUSrc ? imm : op_b. ALUSrc is taken before bubble masking.
- ALU decode:
  - ALUOp 00 → ADD 0010
  - ALUOp 01 → SUB 0110
  - ALUOp 10 uses funct3/instr30:
    - 000: ADD if instr30=0, else SUB
    - 111 → AND 0000
    - 110 → OR 0001
    - 100 → XOR 0011
    - 001 → SLL 0100
    - 101: SRL 0101 if instr30=0, else SRA 1000
    - 010 → SLT 0111
    - 011 → SLTU 1001
  - ALUOp 11: same mapping, but instr30 is ignored except for funct3=101 (SRAI). 000 is always ADD.
- ALU ops:
  - ADD/SUB wrap modulo 2^32.
  - Shifts use B[4:0] only.
  - SLT compares signed; SLTU compares unsigned; result is 0 or 1.
  - Undefined alu_ctrl codes yield result 0.
- zero = (result == 32'h0), computed on the registered result value.

## Timing
- All outputs update only on the rising edge of clk; the inputs sampled at edge N appear after edge N.
- rst=1 at an edge clears out_valid, ctrl, alu_ctrl, result, store_data and sets zero=1 (result 0). This holds when reset arrives mid-stream; the in-flight operation is discarded.
- rst has priority over all other inputs.
- in_valid=0: outputs still update (free-running datapath); out_valid=0 marks them don't-care for consumers.
- No internal state beyond the output register.

## Configuration
- ALU_EXT_OPS_EN defined: full operation set above.
- ALU_EXT_OPS_EN undefined:
  - Only AND/OR/ADD/SUB are decoded.
  - funct3 values 001/010/011/100/101 map to ADD 0010.
  - The instr30 SUB selection still applies for funct3=000 under ALUOp 10.

## Test plan
- R-type add: opcode 0110011, f3=000, instr30=0, a=5, b=7 → next cycle result=12, alu_ctrl=0010, ctrl=0x06, zero=0.
- R-type sub: f3=000, instr30=1, a=7, b=7 → result=0, zero=1, alu_ctrl=0110.
- Load: opcode 0000011, a=0x100, imm=0x10, b=0xFFFF → result=0x110 (imm selected), ctrl=0xE4. Store with the same operands → ctrl=0x90, store_data=0xFFFF.
- Branch: opcode 1100011, a=3, b=3 → ctrl=0x09, zero=1. With a=3, b=4 → zero=0, result=0xFFFFFFFF.
- bubble=1 with R-type → ctrl=0x00. Assert rst during a valid stream → all outputs cleared (zero=1) after that edge.
- SRA, R-type (opcode 0110011), f3=101, instr30=1, a=0x80000000, b=4:
  - macro defined → result=0xF8000000.
  - macro undefined → result=0x80000004.
  - ADDI with instr30=1 (imm=0x400), opcode 0010011 → ADD, not SUB.
